// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with valid/ready handshake and a
//   2-entry (main + skid) buffer. Latency 1 cycle from accept to out_valid.
//   Backpressure: in_ready is registered (!skidValid), so a MEM stall reaches EX one cycle later.
// Ports: clk/rst (sync, active-low); in_valid/in_ready + in_alu_result/in_r2/in_dest/in_ctrl
//   from EX; out_valid/out_ready + out_* to MEM; flush squashes both entries.
// Optional: define EX_MEM_STALL_CNT_EN to add the saturating stall_cnt output.
module ex_mem_stage #(
  parameter int DATA_W = 8,
  parameter int DEST_W = 3,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_r2,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_r2,
  output logic [DEST_W-1:0] out_dest,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] r2;
    logic [DEST_W-1:0] dest;
    logic [CTRL_W-1:0] ctrl;
  } entryT;

  entryT mainQ, mainNext, skidQ, skidNext, inEntry;
  logic  mainValid, mainValidNext;
  logic  skidValid, skidValidNext;
  logic  readyQ;
  logic  accept;

  assign inEntry = '{alu: in_alu_result, r2: in_r2, dest: in_dest, ctrl: in_ctrl};

  // readyQ is the registered ready; gating with rst keeps EX from seeing a
  // stale 1 while reset is held, before the first reset edge lands.
  assign in_ready = readyQ & rst;
  assign accept   = in_valid & in_ready;

  always_comb begin
    mainNext      = mainQ;
    skidNext      = skidQ;
    mainValidNext = mainValid;
    skidValidNext = skidValid;
    if (flush) begin
      // Any same-cycle accept is dropped along with the held entries.
      mainValidNext = 1'b0;
      skidValidNext = 1'b0;
    end else if (!mainValid || out_ready) begin
      // Main slot frees up this cycle: refill it, oldest entry first.
      if (skidValid) begin
        mainNext      = skidQ;
        mainValidNext = 1'b1;
        skidValidNext = accept;
        if (accept) skidNext = inEntry;
      end else if (accept) begin
        mainNext      = inEntry;
        mainValidNext = 1'b1;
      end else begin
        mainValidNext = 1'b0;
      end
    end else if (accept) begin
      // Main is stalled: park the in-flight transfer in the skid slot.
      skidNext      = inEntry;
      skidValidNext = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mainQ     <= '0;
      skidQ     <= '0;
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      readyQ    <= 1'b0;
    end else begin
      mainQ     <= mainNext;
      skidQ     <= skidNext;
      mainValid <= mainValidNext;
      skidValid <= skidValidNext;
      readyQ    <= !skidValidNext;
    end
  end

  assign out_valid      = mainValid;
  assign out_alu_result = mainQ.alu;
  assign out_r2         = mainQ.r2;
  assign out_dest       = mainQ.dest;
  // Bubbles must never write the register file or memory.
  assign out_ctrl       = mainValid ? mainQ.ctrl : '0;

`ifdef EX_MEM_STALL_CNT_EN
  logic [CNT_W-1:0] stallCnt;

  // Cleared only by reset; flush leaves the count alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stallCnt <= '0;
    end else if (mainValid && !out_ready && stallCnt != '1) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign stall_cnt = stallCnt;
`else
  logic unusedCntW;
  assign unusedCntW = |CNT_W;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;
  localparam int DW   = 8;
  localparam int DSTW = 3;
  localparam int CW   = 3;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_alu_result;
  logic [DW-1:0]   in_r2;
  logic [DSTW-1:0] in_dest;
  logic [CW-1:0]   in_ctrl;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_alu_result;
  logic [DW-1:0]   out_r2;
  logic [DSTW-1:0] out_dest;
  logic [CW-1:0]   out_ctrl;
`ifdef EX_MEM_STALL_CNT_EN
  logic [CNTW-1:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(DW), .DEST_W(DSTW), .CTRL_W(CW), .CNT_W(CNTW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_r2(in_r2), .in_dest(in_dest), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_r2(out_r2), .out_dest(out_dest), .out_ctrl(out_ctrl)
`ifdef EX_MEM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Reference model: the stage is a FIFO of depth 2 whose head is the output.
  typedef struct {
    logic [DW-1:0]   alu;
    logic [DW-1:0]   r2;
    logic [DSTW-1:0] dest;
    logic [CW-1:0]   ctrl;
  } entT;

  entT q[$];
  bit  live = 1'b0;     // previous edge was not a reset edge
  int  stallM = 0;
  int  nChk = 0;
  int  nFail = 0;
  bit  chkOn = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit mRdy();
    return live && (rst === 1'b1) && (q.size() < 2);
  endfunction

  task automatic modelStep();
    bit  acc;
    entT e;
    if (!rst) begin
      q.delete();
      live   = 1'b0;
      stallM = 0;
    end else begin
      acc = in_valid && live && (q.size() < 2);
      if (q.size() > 0 && !out_ready && stallM < (1 << CNTW) - 1) stallM++;
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc) begin
          e.alu = in_alu_result; e.r2 = in_r2; e.dest = in_dest; e.ctrl = in_ctrl;
          q.push_back(e);
        end
      end
      live = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] alu, input logic [CW-1:0] ctrl);
    in_valid      = v;
    in_alu_result = alu;
    in_r2         = DW'($urandom);
    in_dest       = DSTW'($urandom);
    in_ctrl       = ctrl;
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chkOn) begin
      chk("in_ready", 32'(in_ready), 32'(mRdy()));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("out_ctrl", 32'(out_ctrl), (q.size() > 0) ? 32'(q[0].ctrl) : 32'd0);
      if (q.size() > 0) begin
        chk("out_alu_result", 32'(out_alu_result), 32'(q[0].alu));
        chk("out_r2", 32'(out_r2), 32'(q[0].r2));
        chk("out_dest", 32'(out_dest), 32'(q[0].dest));
      end
`ifdef EX_MEM_STALL_CNT_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(stallM));
`endif
    end
  end

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 8'h00, 3'b000);

    // Reset for two cycles.
    tick();
    chkOn = 1'b1;
    tick();
    chk("lit_reset_out_valid", 32'(out_valid), 32'd0);
    chk("lit_reset_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("lit_ready_after_release", 32'(in_ready), 32'd1);

    // Stream 0x11, 0x22, 0x33 at full rate.
    drive(1'b1, 8'h11, 3'b010); tick();
    chk("lit_stream_0", 32'(out_alu_result), 32'h11);
    chk("lit_stream_valid", 32'(out_valid), 32'd1);
    drive(1'b1, 8'h22, 3'b010); tick();
    chk("lit_stream_1", 32'(out_alu_result), 32'h22);
    drive(1'b1, 8'h33, 3'b010); tick();
    chk("lit_stream_2", 32'(out_alu_result), 32'h33);
    chk("lit_stream_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 8'h00, 3'b000); tick();
    chk("lit_stream_empty", 32'(out_valid), 32'd0);

    // Back-pressure into the skid slot.
    drive(1'b1, 8'h44, 3'b001); tick();
    out_ready = 1'b0;
    drive(1'b1, 8'h55, 3'b001); tick();
    chk("lit_bp_head", 32'(out_alu_result), 32'h44);
    chk("lit_bp_ready_low", 32'(in_ready), 32'd0);
    drive(1'b0, 8'h00, 3'b000); out_ready = 1'b1; tick();
    chk("lit_bp_skid_out", 32'(out_alu_result), 32'h55);
    chk("lit_bp_ready_back", 32'(in_ready), 32'd1);
    tick();
    chk("lit_bp_drained", 32'(out_valid), 32'd0);

    // Flush with both entries full and a same-cycle accept attempt.
    out_ready = 1'b0;
    drive(1'b1, 8'h66, 3'b110); tick();
    chk("lit_flush_main_ctrl", 32'(out_ctrl), 32'b110);
    drive(1'b1, 8'h77, 3'b001); tick();
    chk("lit_flush_full", 32'(in_ready), 32'd0);
    drive(1'b1, 8'h88, 3'b111); flush = 1'b1; tick();
    chk("lit_flush_valid", 32'(out_valid), 32'd0);
    chk("lit_flush_ctrl", 32'(out_ctrl), 32'd0);
    chk("lit_flush_ready", 32'(in_ready), 32'd1);
    flush = 1'b0; drive(1'b0, 8'h00, 3'b000); out_ready = 1'b1; tick();
    chk("lit_flush_no_0x88", 32'(out_valid), 32'd0);

    // Bubble gating after a ctrl=111 entry drains.
    drive(1'b1, 8'h99, 3'b111); tick();
    chk("lit_bubble_live_ctrl", 32'(out_ctrl), 32'b111);
    drive(1'b0, 8'h00, 3'b111);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lit_bubble_ctrl", 32'(out_ctrl), 32'd0);
    end

    // Reset while stalled with both entries full.
    out_ready = 1'b0;
    drive(1'b1, 8'hA1, 3'b010); tick();
    drive(1'b1, 8'hA2, 3'b010); tick();
    drive(1'b0, 8'h00, 3'b000);
    rst = 1'b0; tick();
    chk("lit_midrst_valid", 32'(out_valid), 32'd0);
    chk("lit_midrst_ready", 32'(in_ready), 32'd0);
    rst = 1'b1; tick();
    chk("lit_midrst_release", 32'(in_ready), 32'd1);
    chk("lit_midrst_empty", 32'(out_valid), 32'd0);

`ifdef EX_MEM_STALL_CNT_EN
    // Saturating stall counter, untouched by flush.
    drive(1'b1, 8'hB0, 3'b010); tick();
    drive(1'b0, 8'h00, 3'b000);
    for (int i = 0; i < 20; i++) tick();
    chk("lit_stall_sat", 32'(stall_cnt), 32'd15);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("lit_stall_after_flush", 32'(stall_cnt), 32'd15);
    out_ready = 1'b1; tick();
`endif

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, DW'($urandom), CW'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 149) != 0);
      tick();
    end

    chkOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
